// File: rtl/spart_pkg.sv
// Shared SPART definitions: receive FSM states, bus register addresses and
// oversampling constants used by both the receiver and the transmitter.
package spart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam logic [1:0]  ADDR_DB_LO      = 2'b10;
  localparam logic [1:0]  ADDR_DB_HI      = 2'b11;
  localparam logic [15:0] DIV_RST_DEFAULT = 16'd325;
  localparam int          OS_RATE         = 16;

endpackage

// File: rtl/spart_tick_gen.sv
// Baud divisor register and oversample tick generator; tick is high while the
// down-counter sits at zero, giving one tick every D+1 cycles.
module spart_tick_gen
  import spart_pkg::*;
#(
  parameter logic [15:0] DIV_RST = DIV_RST_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] ioaddr,
  input  logic [7:0] databus,
  input  logic       div_we,
  input  logic       resync,
  output logic       tick
);

  logic [15:0] div_q, div_d;
  logic [15:0] cnt_q, cnt_d;

  // divisor byte writes and counter reload/decrement
  always_comb begin
    div_d = div_q;
    if (div_we && (ioaddr == ADDR_DB_LO)) begin
      div_d[7:0] = databus;
    end else if (div_we && (ioaddr == ADDR_DB_HI)) begin
      div_d[15:8] = databus;
    end else begin
      div_d = div_q;
    end

    // a new divisor only lands at the next reload, never mid-count
    if (resync || (cnt_q == 16'd0)) begin
      cnt_d = div_q;
    end else begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  // divisor and counter state
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= DIV_RST;
      cnt_q <= DIV_RST;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == 16'd0);

endmodule

// File: rtl/spart_rx.sv
// SPART receiver: synchronises rxd, recovers 8N1 frames at 16x oversampling
// and presents the byte with rda, framing and overrun flags to the bus.
module spart_rx
  import spart_pkg::*;
#(
  parameter int          DATA_BITS   = 8,
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] DIV_RST     = DIV_RST_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           ioaddr,
  input  logic [7:0]           databus,
  input  logic                 div_we,
  input  logic                 rxd,
  input  logic                 rx_rd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rda,
  output logic                 frm_err,
  output logic                 ovr_err
);

  localparam int             IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [3:0]     OS_MID   = 4'(OS_RATE / 2 - 1);
  localparam logic [3:0]     OS_LAST  = 4'(OS_RATE - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  rx_state_t              state_q, state_d;
  logic [3:0]             os_cnt_q, os_cnt_d;
  logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rda_q, rda_d;
  logic                   frm_err_q, frm_err_d;
  logic                   ovr_err_q, ovr_err_d;
  logic                   rxd_s, tick_s, resync_s, done_s;

  spart_tick_gen #(.DIV_RST(DIV_RST)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .ioaddr  (ioaddr),
    .databus (databus),
    .div_we  (div_we),
    .resync  (resync_s),
    .tick    (tick_s)
  );

  assign sync_d = {sync_q[SYNC_STAGES-2:0], rxd};
  assign rxd_s  = sync_q[SYNC_STAGES-1];

  // receive FSM: start qualification, data shifting and stop sampling
  always_comb begin
    state_d   = state_q;
    os_cnt_d  = os_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    resync_s  = 1'b0;
    done_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rxd_s) begin
          state_d  = START;
          os_cnt_d = 4'd0;
          resync_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (tick_s && (os_cnt_q == OS_MID)) begin
          os_cnt_d  = 4'd0;
          bit_idx_d = '0;
          state_d   = rxd_s ? IDLE : DATA;
        end else if (tick_s) begin
          os_cnt_d = os_cnt_q + 4'd1;
        end else begin
          os_cnt_d = os_cnt_q;
        end
      end
      DATA: begin
        if (tick_s && (os_cnt_q == OS_LAST)) begin
          os_cnt_d = 4'd0;
          shift_d  = {rxd_s, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == IDX_LAST) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end else if (tick_s) begin
          os_cnt_d = os_cnt_q + 4'd1;
        end else begin
          os_cnt_d = os_cnt_q;
        end
      end
      STOP: begin
        if (tick_s && (os_cnt_q == OS_LAST)) begin
          os_cnt_d = 4'd0;
          done_s   = 1'b1;
          state_d  = IDLE;
        end else if (tick_s) begin
          os_cnt_d = os_cnt_q + 4'd1;
        end else begin
          os_cnt_d = os_cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // status flags; a completing byte overrides a same-cycle read
  always_comb begin
    rx_data_d = rx_data_q;
    rda_d     = rda_q;
    frm_err_d = frm_err_q;
    ovr_err_d = ovr_err_q;
    if (done_s) begin
      rx_data_d = shift_q;
      rda_d     = 1'b1;
      frm_err_d = ~rxd_s;
      ovr_err_d = rda_q & ~rx_rd;
    end else if (rx_rd) begin
      rda_d     = 1'b0;
      frm_err_d = 1'b0;
      ovr_err_d = 1'b0;
    end else begin
      rda_d = rda_q;
    end
  end

  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '1;
      state_q   <= IDLE;
      os_cnt_q  <= 4'd0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      rx_data_q <= '0;
      rda_q     <= 1'b0;
      frm_err_q <= 1'b0;
      ovr_err_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      os_cnt_q  <= os_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      rx_data_q <= rx_data_d;
      rda_q     <= rda_d;
      frm_err_q <= frm_err_d;
      ovr_err_q <= ovr_err_d;
    end
  end

  assign rx_data = rx_data_q;
  assign rda     = rda_q;
  assign frm_err = frm_err_q;
  assign ovr_err = ovr_err_q;

endmodule

// File: tb/tb_spart_rx.sv
// Scoreboard bench for spart_rx: frames are driven on rxd, the expected byte
// and flags are queued, and a monitor compares whenever a new byte appears.
module tb_spart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] ioaddr = 2'b00;
  logic [7:0] databus = 8'h00;
  logic       div_we = 1'b0;
  logic       rxd = 1'b1;
  logic       rx_rd = 1'b0;
  logic [7:0] rx_data;
  logic       rda, frm_err, ovr_err;

  spart_rx dut (
    .clk(clk), .rst(rst), .ioaddr(ioaddr), .databus(databus), .div_we(div_we),
    .rxd(rxd), .rx_rd(rx_rd), .rx_data(rx_data), .rda(rda),
    .frm_err(frm_err), .ovr_err(ovr_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] data; logic frm; logic ovr; } exp_t;
  exp_t exp_q[$];

  int   checks = 0;
  int   errors = 0;
  logic abort = 1'b0;
  logic pending = 1'b0;   // a byte has been delivered and not yet read
  logic [7:0] last_b = 8'h00;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // monitor: a new byte is visible when rda rises or the held byte/flags change
  logic       p_rda = 1'b0, p_frm = 1'b0, p_ovr = 1'b0;
  logic [7:0] p_data = 8'h00;
  always @(negedge clk) begin
    if (rst) begin
      p_rda = 1'b0; p_frm = 1'b0; p_ovr = 1'b0; p_data = 8'h00;
    end else begin
      if (rda && (!p_rda || rx_data !== p_data || frm_err !== p_frm || (ovr_err && !p_ovr))) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte actual=%0h required=none", rx_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rx_data", {8'h00, rx_data}, {8'h00, e.data});
          chk("frm_err", {15'h0, frm_err}, {15'h0, e.frm});
          chk("ovr_err", {15'h0, ovr_err}, {15'h0, e.ovr});
        end
      end
      p_rda = rda; p_frm = frm_err; p_ovr = ovr_err; p_data = rx_data;
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop, input int bc);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = bits[i];
      for (int c = 0; c < bc; c++) begin
        if (abort) begin
          rxd = 1'b1;
          return;
        end
        @(negedge clk);
      end
    end
  endtask

  // reference model: expected byte carries ovr if the previous one is unread
  task automatic expect_byte(input logic [7:0] b, input logic stop, input logic ovr);
    exp_t e;
    e.data = b; e.frm = ~stop; e.ovr = ovr;
    exp_q.push_back(e);
    pending = 1'b1;
    last_b  = b;
  endtask

  task automatic do_read();
    rx_rd = 1'b1;
    @(negedge clk);
    rx_rd = 1'b0;
    chk("rda_cleared", {15'h0, rda}, 16'h0);
    chk("frm_cleared", {15'h0, frm_err}, 16'h0);
    chk("ovr_cleared", {15'h0, ovr_err}, 16'h0);
    pending = 1'b0;
  endtask

  task automatic frame(input logic [7:0] b, input logic stop, input int bc, input logic rd);
    expect_byte(b, stop, pending);
    send_frame(b, stop, bc);
    if (rd) do_read();
  endtask

  task automatic wr_div(input logic [1:0] a, input logic [7:0] d);
    ioaddr = a; databus = d; div_we = 1'b1;
    @(negedge clk);
    div_we = 1'b0;
  endtask

  task automatic tick_period(output int period);
    int n;
    n = 0;
    while (!dut.u_tick.tick && n < 1000) begin @(negedge clk); n++; end
    chk("tick_seen", {15'h0, n < 1000}, 16'h1);
    @(negedge clk);
    period = 1;
    while (!dut.u_tick.tick && period < 1000) begin @(negedge clk); period++; end
  endtask

  initial begin
    int p;
    logic [7:0] b;
    logic rd_now;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_rx_data", {8'h00, rx_data}, 16'h0);
    chk("reset_rda", {15'h0, rda}, 16'h0);
    chk("reset_frm", {15'h0, frm_err}, 16'h0);
    chk("reset_ovr", {15'h0, ovr_err}, 16'h0);
    chk("reset_div", dut.u_tick.div_q, 16'd325);

    wr_div(2'b10, 8'h03);
    wr_div(2'b11, 8'h00);
    chk("div_write", dut.u_tick.div_q, 16'd3);
    wr_div(2'b00, 8'hFF);
    wr_div(2'b01, 8'hFF);
    chk("div_bad_addr", dut.u_tick.div_q, 16'd3);
    tick_period(p);
    chk("tick_period_a", 16'(p), 16'd4);
    tick_period(p);
    chk("tick_period_b", 16'(p), 16'd4);

    frame(8'hA5, 1'b1, 64, 1'b1);

    // framing error, then back-to-back 00 read while it is arriving
    expect_byte(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 64);
    expect_byte(8'h00, 1'b1, 1'b0);
    fork
      send_frame(8'h00, 1'b1, 64);
      begin repeat (8) @(negedge clk); do_read(); end
    join
    do_read();

    // overrun without a read
    frame(8'h11, 1'b1, 64, 1'b0);
    frame(8'h22, 1'b1, 64, 1'b0);
    chk("ovr_set", {15'h0, ovr_err}, 16'h1);
    chk("ovr_data", {8'h00, rx_data}, 16'h22);
    do_read();

    // read coincident with the stop-bit completion (610 cycles after the edge)
    frame(8'h11, 1'b1, 64, 1'b0);
    expect_byte(8'h22, 1'b1, 1'b0);
    fork
      send_frame(8'h22, 1'b1, 64);
      begin repeat (610) @(negedge clk); rx_rd = 1'b1; @(negedge clk); rx_rd = 1'b0; end
    join
    chk("collide_rda", {15'h0, rda}, 16'h1);
    chk("collide_ovr", {15'h0, ovr_err}, 16'h0);
    do_read();

    // glitch shorter than half a bit
    rxd = 1'b0;
    repeat (12) @(negedge clk);
    rxd = 1'b1;
    repeat (100) @(negedge clk);
    chk("false_start_rda", {15'h0, rda}, 16'h0);
    frame(8'h5A, 1'b1, 64, 1'b1);

    // randomized bytes, reads sometimes skipped to provoke overruns
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      if (pending && b == last_b) b = b ^ 8'h01;
      rd_now = (i == 5) ? 1'b1 : 1'($urandom_range(0, 1));
      frame(b, 1'b1, 64, rd_now);
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end

    // reset during data bit 4
    fork
      send_frame(8'hE7, 1'b1, 64);
      begin
        repeat (340) @(negedge clk);
        rst = 1'b1; abort = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0; abort = 1'b0;
      end
    join
    pending = 1'b0;
    repeat (200) @(negedge clk);
    chk("midrst_rda", {15'h0, rda}, 16'h0);
    chk("midrst_frm", {15'h0, frm_err}, 16'h0);
    chk("midrst_ovr", {15'h0, ovr_err}, 16'h0);
    chk("midrst_data", {8'h00, rx_data}, 16'h0);
    chk("midrst_div", dut.u_tick.div_q, 16'd325);

    // divisor change during the stop bit of a frame sent at D=3
    wr_div(2'b10, 8'h03);
    wr_div(2'b11, 8'h00);
    expect_byte(8'hC3, 1'b1, 1'b0);
    fork
      send_frame(8'hC3, 1'b1, 64);
      begin repeat (580) @(negedge clk); wr_div(2'b10, 8'h01); end
    join
    do_read();
    chk("new_div", dut.u_tick.div_q, 16'd1);
    frame(8'h96, 1'b1, 32, 1'b1);
    frame(8'($urandom), 1'b1, 32, 1'b1);

    repeat (20) @(negedge clk);
    chk("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spart_rx.md
# spart_rx

Serial receive half of the SPART. Recovers 8N1 asynchronous frames from the `rxd` pin using 16x oversampling, paced by a programmable baud divisor written over the processor I/O bus. Delivers each byte to the bus interface with a receive-data-available flag plus framing and overrun status. Sits beside the SPART transmitter and shares its divisor register addresses.

## Interface

**Parameters**

- `DATA_BITS`, 8: data bits per frame, sent LSB first.
- `SYNC_STAGES`, 2: flip-flop stages in the `rxd` synchroniser (minimum 2).
- `DIV_RST`, 16'd325: divisor value after reset.

**Ports**

- `clk`  in  1: system clock; the block uses this single clock.
- `rst`  in  1: synchronous, active-high reset.
- `ioaddr`  in  2: register select; 2'b10 is DB low, 2'b11 is DB high.
- `databus`  in  8: write data for the divisor bytes.
- `div_we`  in  1: divisor write strobe; qualified by `ioaddr`.
- `rxd`  in  1: asynchronous serial input; idle level is 1.
- `rx_rd`  in  1: one-cycle strobe; the bus has consumed `rx_data`.
- `rx_data`  out  DATA_BITS: last received byte.
- `rda`  out  1: receive data available.
- `frm_err`  out  1: stop bit of the last byte was sampled as 0.
- `ovr_err`  out  1: a byte completed while `rda` was still 1.

## Operation

**Divisor and oversample tick**

- A 16-bit divisor register D:
  - `div_we` with `ioaddr` 2'b10 writes D[7:0].
  - `div_we` with `ioaddr` 2'b11 writes D[15:8].
  - Other addresses are ignored.
- A 16-bit down-counter reloads with D when it reaches 0, or when the FSM requests a resync. Otherwise it decrements every cycle.
- `tick` is asserted while the counter is 0. The tick period is D+1 cycles. D=0 gives a tick every cycle.
- A divisor write takes effect at the next reload. The running count is not disturbed.

**Receive FSM**

- The FSM uses a 4-bit oversample counter `os_cnt` and a bit index.
- IDLE:
  - When synchronised `rxd`=0, enter START, clear `os_cnt`, and resync the tick counter.
- START:
  - Count ticks. On the 8th tick (mid start bit), sample `rxd`.
  - If the sample is 0, go to DATA with `os_cnt` cleared.
  - If the sample is 1 (false start/glitch), go to IDLE.
- DATA:
  - On every 16th tick, shift `rxd` into a shift register, LSB first.
  - After DATA_BITS samples, go to STOP.
- STOP:
  - On the 16th tick, sample the stop bit.
  - Load `rx_data` from the shift register.
  - Set `frm_err` to the inverse of the sample.
  - Set `rda`=1. If `rda` was already 1 and no `rx_rd` arrives this cycle, also set `ovr_err`=1.
  - Return to IDLE. A framing error does not block the next frame.
- `rx_rd` clears `rda`, `frm_err` and `ovr_err`.
- If `rx_rd` arrives in the same cycle that a byte completes, the completion wins:
  - `rda`=1 with the new byte.
  - `ovr_err` is not set.
  - `frm_err` reflects the new byte.
- `rx_rd` while `rda`=0 has no effect.
- `div_we` during a frame does not abort the frame.

## Timing

- Reset values: `rx_data`=0, `rda`=0, `frm_err`=0, `ovr_err`=0. Also: FSM in IDLE, D=`DIV_RST`, tick counter=`DIV_RST`, synchroniser flops=1.
- Reset takes priority over all other inputs. A reset mid-frame discards the frame and returns to IDLE with no flags set.
- Synchroniser latency is SYNC_STAGES cycles. The FSM sees the start edge SYNC_STAGES+1 cycles after the pin edge at the earliest.
- The data-bit sample points are 16 ticks apart. They start 24 ticks after start-edge detection.
- `rda` and `rx_data` update on the clock edge ending the cycle in which the stop-bit tick is seen. They are registered outputs with one cycle of latency from the stop sample.
- All flags are held until `rx_rd` or `rst`.

## Structure

- Package `spart_pkg` holds:
  - the FSM state enum `rx_state_t` (IDLE, START, DATA, STOP);
  - `ADDR_DB_LO`=2'b10 and `ADDR_DB_HI`=2'b11;
  - `DIV_RST_DEFAULT`=16'd325 and `OS_RATE`=16.
  - The transmitter imports the same package.
- Sub-module `spart_tick_gen`: the divisor register, the down-counter and `tick`, with a `resync` input. It is reusable by the transmitter.
- The rest lives in `spart_rx`: synchroniser, FSM, shift register and status flags.

## Test plan

- **Reset defaults:** assert `rst` 3 cycles with `rxd`=1 -> all outputs 0 and D=325. Write D=3 (lo=8'h03, hi=8'h00) -> `tick` every 4 cycles.
- **Basic byte:** with D=3 (64 cycles/bit), drive frame 8'hA5 with stop=1 -> `rda`=1, `rx_data`=8'hA5, `frm_err`=0. Then `rx_rd` -> `rda`=0 the next cycle.
- **Framing error:** send 8'h3C with stop=0 -> `rda`=1, `rx_data`=8'h3C, `frm_err`=1. Then a back-to-back 8'h00 with stop=1 -> received correctly.
- **Overrun and read collision:**
  - Send 8'h11, then 8'h22 with no read -> `ovr_err`=1, `rx_data`=8'h22.
  - Repeat with `rx_rd` coincident with the second completion -> `rda`=1, `ovr_err`=0.
- **False start:** a 0 pulse on `rxd` lasting 12 cycles (< 8 ticks at D=3) -> FSM back to IDLE, no `rda`. Then a valid 8'h5A -> received.
- **Reset mid-frame and divisor write:**
  - Assert `rst` during bit 4 of a frame -> IDLE, `rda`=0, no flags.
  - Write D=1 mid-frame of 8'hC3 sent at D=3 timing -> the current frame still completes, and the next frame at the new rate is received correctly.
